// File: rtl/des_block_packer.sv
// rtl/des_block_packer.sv - packs a byte stream into 64-bit DES plaintext blocks with last-block marking
// Build option DES_PKCS7_PAD_EN: PKCS#7 fill of the last block plus a trailing pad block on exact multiples.
module des_block_packer #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  BYTE_IN,
   input  logic        BYTE_VALID,
   input  logic        BYTE_LAST,
   output logic        BYTE_READY,
   output logic [63:0] PLAIN_TEXT,
   output logic        BLOCK_VALID,
   input  logic        BLOCK_READY,
   output logic        BLOCK_LAST,
   output logic [3:0]  BLOCK_BYTES
);

`ifdef DES_PKCS7_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   localparam logic [63:0] PAD_BLOCK = {8{8'h08}};

   typedef enum logic [1:0] {FILL, HOLD, PADBLK} state_t;

   state_t      state;
   logic [2:0]  cnt;
   logic        pad_pending;
   logic        accept;
   logic        handshake;
   logic        block_done;
   logic [7:0]  fill_byte;
   logic [63:0] written;

   // Bit offset of a byte lane inside PLAIN_TEXT.
   function automatic int lane_off(input int lane);
      return MSB_FIRST ? (7 - lane) * 8 : lane * 8;
   endfunction

   assign accept     = BYTE_VALID & BYTE_READY;
   assign handshake  = BLOCK_VALID & BLOCK_READY;
   assign block_done = BYTE_LAST | (cnt == 3'd7);

   // Pad value for a short last block is the number of unused lanes, 7-cnt.
   always_comb begin
      fill_byte = PAD_EN ? (8'd7 - {5'd0, cnt}) : 8'd0;
      written   = PLAIN_TEXT;
      for (int i = 0; i < 8; i++) begin
         if (3'(i) == cnt)
            written[lane_off(i) +: 8] = BYTE_IN;
         else if (BYTE_LAST && (3'(i) > cnt))
            written[lane_off(i) +: 8] = fill_byte;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= FILL;
         cnt         <= 3'd0;
         pad_pending <= 1'b0;
         PLAIN_TEXT  <= 64'd0;
         BLOCK_VALID <= 1'b0;
         BLOCK_LAST  <= 1'b0;
         BLOCK_BYTES <= 4'd0;
         BYTE_READY  <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               BYTE_READY <= 1'b1;
               if (accept) begin
                  PLAIN_TEXT <= written;
                  if (block_done) begin
                     state       <= HOLD;
                     cnt         <= 3'd0;
                     BLOCK_VALID <= 1'b1;
                     BYTE_READY  <= 1'b0;
                     BLOCK_BYTES <= {1'b0, cnt} + 4'd1;
                     // An exactly full last block defers LAST to the pad block when padding.
                     BLOCK_LAST  <= BYTE_LAST & ~(PAD_EN & (cnt == 3'd7));
                     pad_pending <= PAD_EN & BYTE_LAST & (cnt == 3'd7);
                  end else begin
                     cnt <= cnt + 3'd1;
                  end
               end
            end

            HOLD: begin
               if (handshake) begin
                  BLOCK_VALID <= 1'b0;
                  if (pad_pending) begin
                     state       <= PADBLK;
                     pad_pending <= 1'b0;
                     PLAIN_TEXT  <= PAD_BLOCK;
                     BLOCK_BYTES <= 4'd0;
                     BLOCK_LAST  <= 1'b1;
                  end else begin
                     state      <= FILL;
                     BYTE_READY <= 1'b1;
                  end
               end
            end

            PADBLK: begin
               if (!BLOCK_VALID) begin
                  BLOCK_VALID <= 1'b1;
               end else if (BLOCK_READY) begin
                  BLOCK_VALID <= 1'b0;
                  state       <= FILL;
                  BYTE_READY  <= 1'b1;
               end
            end

            default: begin
               state      <= FILL;
               BYTE_READY <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_des_block_packer.sv
// tb/tb_des_block_packer.sv - randomized self-checking bench for des_block_packer (both lane orders)
// Honours DES_PKCS7_PAD_EN in its reference model.
module tb_des_block_packer;

`ifdef DES_PKCS7_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  BYTE_IN = 8'd0;
   logic        BYTE_VALID = 1'b0;
   logic        BYTE_LAST = 1'b0;
   logic        BLOCK_READY = 1'b0;

   logic        byte_ready_m, valid_m, last_m;
   logic [63:0] plain_m;
   logic [3:0]  bytes_m;
   logic        byte_ready_l, valid_l, last_l;
   logic [63:0] plain_l;
   logic [3:0]  bytes_l;

   int checks = 0;
   int failures = 0;

   logic [7:0]  msg[$];
   logic [63:0] exp_msb[$], exp_lsb[$], obs_msb[$], obs_lsb[$];
   logic        exp_last[$], obs_last[$];
   logic [3:0]  exp_bytes[$], obs_bytes[$];

   des_block_packer #(.MSB_FIRST(1'b1)) dut (
      .CLK(CLK), .RST(RST), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_LAST(BYTE_LAST),
      .BYTE_READY(byte_ready_m), .PLAIN_TEXT(plain_m), .BLOCK_VALID(valid_m),
      .BLOCK_READY(BLOCK_READY), .BLOCK_LAST(last_m), .BLOCK_BYTES(bytes_m));

   des_block_packer #(.MSB_FIRST(1'b0)) dut_lsb (
      .CLK(CLK), .RST(RST), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_LAST(BYTE_LAST),
      .BYTE_READY(byte_ready_l), .PLAIN_TEXT(plain_l), .BLOCK_VALID(valid_l),
      .BLOCK_READY(BLOCK_READY), .BLOCK_LAST(last_l), .BLOCK_BYTES(bytes_l));

   always #5 CLK = ~CLK;

   // Reference: chop the message into 8-byte chunks and fill/pad each by the packing rules.
   function automatic void build_expected();
      int n, k;
      bit last;
      logic [7:0]  lane[8];
      logic [63:0] vm, vl;
      exp_msb.delete(); exp_lsb.delete(); exp_last.delete(); exp_bytes.delete();
      n = msg.size();
      for (int b = 0; b < n; b += 8) begin
         k    = (n - b > 8) ? 8 : n - b;
         last = (b + k == n);
         for (int i = 0; i < 8; i++)
            lane[i] = (i < k) ? msg[b + i] : (PAD ? 8'(8 - k) : 8'h00);
         vm = 64'd0;
         vl = 64'd0;
         for (int i = 0; i < 8; i++) begin
            vm = (vm << 8) | 64'(lane[i]);
            vl = vl | (64'(lane[i]) << (8 * i));
         end
         if (PAD && last && k == 8) begin
            exp_msb.push_back(vm); exp_lsb.push_back(vl); exp_last.push_back(1'b0); exp_bytes.push_back(4'd8);
            exp_msb.push_back({8{8'h08}}); exp_lsb.push_back({8{8'h08}});
            exp_last.push_back(1'b1); exp_bytes.push_back(4'd0);
         end else begin
            exp_msb.push_back(vm); exp_lsb.push_back(vl); exp_last.push_back(last); exp_bytes.push_back(4'(k));
         end
      end
   endfunction

   // mode 0: consumer always ready, 1: random ready, 2: stall the first 5 valid cycles.
   task automatic run_msg(input string name, input int mode, input int gap_pct, output int stalls);
      int n, idx, cycles, nmin;
      bit expect_valid, after_hs, next_pad, prev_hold;
      logic [63:0] prev_m, prev_l;
      logic        prev_last;
      logic [3:0]  prev_bytes;
      n = msg.size(); idx = 0; cycles = 0; stalls = 0;
      expect_valid = 0; after_hs = 0; next_pad = 0; prev_hold = 0;
      prev_m = '0; prev_l = '0; prev_last = 0; prev_bytes = '0;
      build_expected();
      obs_msb.delete(); obs_lsb.delete(); obs_last.delete(); obs_bytes.delete();
      @(posedge CLK); #1;
      BYTE_VALID = 0; BLOCK_READY = 0;
      while (obs_msb.size() < exp_msb.size() && cycles < 3000) begin
         @(negedge CLK);
         cycles++;
         if (expect_valid) begin
            checks++;
            if (valid_m !== 1'b1) begin failures++; $display("FAIL %s latency: BLOCK_VALID=%b expected 1", name, valid_m); end
            expect_valid = 0;
         end
         if (after_hs) begin
            checks++;
            if (valid_m !== 1'b0) begin failures++; $display("FAIL %s drop: BLOCK_VALID=%b expected 0", name, valid_m); end
            if (!next_pad) begin
               checks++;
               if (byte_ready_m !== 1'b1) begin failures++; $display("FAIL %s refill: BYTE_READY=%b expected 1", name, byte_ready_m); end
            end
            after_hs = 0;
         end
         if (prev_hold) begin
            checks++;
            if ({plain_m, plain_l, last_m, bytes_m} !== {prev_m, prev_l, prev_last, prev_bytes}) begin
               failures++;
               $display("FAIL %s hold: got %h/%h/%b/%0d expected %h/%h/%b/%0d", name,
                        plain_m, plain_l, last_m, bytes_m, prev_m, prev_l, prev_last, prev_bytes);
            end
         end
         if (valid_m) begin
            checks++;
            if (byte_ready_m !== 1'b0) begin failures++; $display("FAIL %s busy: BYTE_READY=%b expected 0", name, byte_ready_m); end
         end
         if (BYTE_VALID && byte_ready_m) begin
            if ((idx % 8 == 7) || (idx == n - 1)) expect_valid = 1;
            idx++;
         end
         prev_hold = valid_m && !BLOCK_READY;
         prev_m = plain_m; prev_l = plain_l; prev_last = last_m; prev_bytes = bytes_m;
         if (valid_m && !BLOCK_READY) stalls++;
         if (valid_m && BLOCK_READY) begin
            checks++;
            if ({valid_l, last_l, bytes_l} !== {1'b1, last_m, bytes_m}) begin
               failures++; $display("FAIL %s lsb_flags: got %b/%b/%0d expected 1/%b/%0d", name, valid_l, last_l, bytes_l, last_m, bytes_m);
            end
            obs_msb.push_back(plain_m); obs_lsb.push_back(plain_l);
            obs_last.push_back(last_m); obs_bytes.push_back(bytes_m);
            after_hs = 1;
            next_pad = (obs_msb.size() < exp_bytes.size()) && (exp_bytes[obs_msb.size()] == 4'd0);
         end
         @(posedge CLK); #1;
         BYTE_VALID = (idx < n) && ($urandom_range(99) >= gap_pct);
         BYTE_IN    = (idx < n) ? msg[idx] : 8'($urandom);
         BYTE_LAST  = BYTE_VALID ? (idx == n - 1) : 1'($urandom_range(1));
         case (mode)
            0:       BLOCK_READY = 1'b1;
            1:       BLOCK_READY = 1'($urandom_range(1));
            default: BLOCK_READY = !(valid_m && stalls < 5);
         endcase
      end
      checks++;
      if (cycles >= 3000) begin failures++; $display("FAIL %s timeout: blocks=%0d expected %0d", name, obs_msb.size(), exp_msb.size()); end
      @(negedge CLK);
      if (after_hs) begin
         checks++;
         if (valid_m !== 1'b0) begin failures++; $display("FAIL %s drop: BLOCK_VALID=%b expected 0", name, valid_m); end
         checks++;
         if (byte_ready_m !== 1'b1) begin failures++; $display("FAIL %s refill: BYTE_READY=%b expected 1", name, byte_ready_m); end
      end
      BYTE_VALID = 0; BYTE_LAST = 0; BLOCK_READY = 0;
      checks++;
      if (obs_msb.size() != exp_msb.size()) begin
         failures++; $display("FAIL %s count: blocks=%0d expected %0d", name, obs_msb.size(), exp_msb.size());
      end
      nmin = (obs_msb.size() < exp_msb.size()) ? obs_msb.size() : exp_msb.size();
      for (int j = 0; j < nmin; j++) begin
         checks++;
         if ({obs_msb[j], obs_last[j], obs_bytes[j]} !== {exp_msb[j], exp_last[j], exp_bytes[j]}) begin
            failures++;
            $display("FAIL %s block%0d: got %h last=%b bytes=%0d expected %h last=%b bytes=%0d", name, j,
                     obs_msb[j], obs_last[j], obs_bytes[j], exp_msb[j], exp_last[j], exp_bytes[j]);
         end
         checks++;
         if (obs_lsb[j] !== exp_lsb[j]) begin
            failures++; $display("FAIL %s lsb_block%0d: got %h expected %h", name, j, obs_lsb[j], exp_lsb[j]);
         end
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({plain_m, valid_m, last_m, bytes_m, byte_ready_m, plain_l, valid_l, last_l, bytes_l, byte_ready_l} !== '0) begin
         failures++;
         $display("FAIL %s: got %h/%b/%b/%0d/%b lsb %h/%b expected all zero", name,
                  plain_m, valid_m, last_m, bytes_m, byte_ready_m, plain_l, valid_l);
      end
   endtask

   task automatic feed_bytes(input string name, input int count, input logic [7:0] base);
      int acc = 0;
      int c = 0;
      @(posedge CLK); #1;
      BYTE_VALID = 1; BYTE_LAST = 0; BYTE_IN = base; BLOCK_READY = 0;
      while (acc < count && c < 100) begin
         @(negedge CLK);
         c++;
         if (BYTE_VALID && byte_ready_m) acc++;
         @(posedge CLK); #1;
         BYTE_IN = base + 8'(acc);
         BYTE_VALID = (acc < count);
      end
      checks++;
      if (acc != count) begin failures++; $display("FAIL %s feed: accepted %0d expected %0d", name, acc, count); end
   endtask

   task automatic test_reset();
      #2;
      check_zero("reset_state");
      @(negedge CLK);
      RST = 0;
      @(posedge CLK); #1;
      checks++;
      if (byte_ready_m !== 1'b1) begin failures++; $display("FAIL reset_release: BYTE_READY=%b expected 1", byte_ready_m); end
   endtask

   task automatic test_full_block();
      int s;
      msg.delete();
      for (int i = 1; i <= 8; i++) msg.push_back(8'(i));
      run_msg("full_block", 0, 0, s);
   endtask

   task automatic test_backpressure();
      int s;
      msg.delete();
      for (int i = 1; i <= 8; i++) msg.push_back(8'(i));
      run_msg("backpressure", 2, 0, s);
      checks++;
      if (s != 5) begin failures++; $display("FAIL backpressure stalls: got %0d expected 5", s); end
   endtask

   task automatic test_short_last();
      int s;
      msg.delete();
      msg.push_back(8'hAA); msg.push_back(8'hBB); msg.push_back(8'hCC);
      run_msg("short_last", 0, 0, s);
   endtask

   task automatic test_exact_multiple();
      int s;
      msg.delete();
      for (int i = 0; i < 8; i++) msg.push_back(8'h11);
      run_msg("exact_multiple", 1, 20, s);
   endtask

   task automatic test_async_reset();
      int s;
      feed_bytes("async_mid_block", 4, 8'h91);
      #2 RST = 1;
      #1 check_zero("async_mid_block_zero");
      @(negedge CLK); RST = 0;
      feed_bytes("async_mid_hold", 8, 8'hE1);
      checks++;
      if (valid_m !== 1'b1) begin failures++; $display("FAIL async_mid_hold valid: got %b expected 1", valid_m); end
      #2 RST = 1;
      #1 check_zero("async_mid_hold_zero");
      @(negedge CLK); RST = 0;
      msg.delete();
      for (int i = 0; i < 8; i++) msg.push_back(8'h21 + 8'(i));
      run_msg("after_reset", 0, 0, s);
   endtask

   task automatic test_random();
      int s, n;
      for (int r = 0; r < 8; r++) begin
         msg.delete();
         n = (r == 0) ? 16 : int'($urandom_range(1, 40));
         for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
         run_msg("random", (r < 2) ? 0 : 1, (r < 2) ? 0 : 30, s);
      end
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      test_reset();
      test_full_block();
      test_backpressure();
      test_short_last();
      test_exact_multiple();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
